// File: rtl/led_channel_timer.sv
// led_channel_timer: CHANNELS independent LED/GPIO outputs driven from one
// shared prescaler tick. Each channel runs as OFF, ON, BLINK (toggle every
// eff ticks) or ONESHOT (high for eff ticks, then a one-cycle done strobe).
// eff = (period == 0) ? 1 : period.
//
// Configuration handshake: cfg_we is a single-cycle strobe with no ready
// signal; every cycle with cfg_we=1 is exactly one write, applied on that
// clock edge. Writes to cfg_addr >= CHANNELS are dropped.
//
// dbg_mode exposes each channel's mode register (channel i at bits
// [2*i+1:2*i]) so the per-channel state machines can be observed.
module led_channel_timer #(
    parameter int CLK_FREQ_HZ = 16_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    localparam int AW         = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [1:0]             cfg_mode,
    input  logic [CNT_WIDTH-1:0]   cfg_period,
    output logic [CHANNELS-1:0]    q,
    output logic [CHANNELS-1:0]    done,
    output logic                   tick,
    output logic [2*CHANNELS-1:0]  dbg_mode
);

    localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW       = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    // One bit wider than cfg_addr so CHANNELS itself is representable.
    localparam logic [AW:0]   CH_LIM     = (AW + 1)'(CHANNELS);

    // A prescaler below 2 cannot produce a one-cycle tick pulse.
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("led_channel_timer: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end

    if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
        $error("led_channel_timer: CHANNELS must be in 1..16");
    end

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    // Shared prescaler.
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_w;

    // Per-channel state.
    mode_e                mode_q   [CHANNELS];
    mode_e                mode_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] period_q [CHANNELS];
    logic [CNT_WIDTH-1:0] period_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q    [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d    [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_last [CHANNELS];
    logic [CHANNELS-1:0]  q_q, q_d;
    logic [CHANNELS-1:0]  done_q, done_d;

    logic                 addr_ok;

    assign tick_w  = (presc_q == PRESC_LAST);
    assign addr_ok = ({1'b0, cfg_addr} < CH_LIM);

    // Terminal count per channel: eff-1, where a zero period behaves as 1.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_last
        assign cnt_last[g] = (period_q[g] == '0) ? '0
                                                 : period_q[g] - CNT_WIDTH'(1);
    end

    // Prescaler next state: free-running 0..PRESCALE-1 wrap.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Channel next state: a write to the channel wins over its tick.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            q_d[i]      = q_q[i];
            done_d[i]   = 1'b0;

            if (cfg_we && addr_ok && (cfg_addr == AW'(i))) begin
                mode_d[i]   = mode_e'(cfg_mode);
                period_d[i] = cfg_period;
                cnt_d[i]    = '0;
                // ON and ONESHOT start high; BLINK restarts its phase low.
                q_d[i]      = (mode_e'(cfg_mode) == MODE_ON) ||
                              (mode_e'(cfg_mode) == MODE_ONESHOT);
            end else if (tick_w) begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (cnt_q[i] == cnt_last[i]) begin
                            q_d[i]   = ~q_q[i];
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q[i] == cnt_last[i]) begin
                            // q falls in the same cycle done rises.
                            q_d[i]    = 1'b0;
                            mode_d[i] = MODE_OFF;
                            cnt_d[i]  = '0;
                            done_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        // OFF and ON ignore ticks; the counter stays parked.
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Channel registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            q_q    <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            q_q    <= q_d;
            done_q <= done_d;
        end
    end

    // Pack channel modes for observation.
    always_comb begin
        dbg_mode = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            dbg_mode[2*i +: 2] = mode_q[i];
        end
    end

    assign q    = q_q;
    assign done = done_q;
    assign tick = tick_w;

endmodule

// File: tb/tb_led_channel_timer.sv
// Bench for led_channel_timer. A 4-channel instance and a 3-channel instance
// share clock, reset and configuration inputs; the 3-channel one must match
// the first three channels of the reference model and ignore address 3.
// The reference model tracks, per channel, the configured mode, the
// effective period and the number of ticks seen since the last write.
module tb_led_channel_timer;

    localparam int CLK_FREQ_HZ = 100;
    localparam int TICK_HZ     = 10;
    localparam int PRESCALE    = CLK_FREQ_HZ / TICK_HZ;
    localparam int CHANNELS    = 4;
    localparam int CNT_WIDTH   = 8;

    // Clock / reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 cfg_we;
    logic [1:0]           cfg_addr;
    logic [1:0]           cfg_mode;
    logic [CNT_WIDTH-1:0] cfg_period;

    logic [3:0] q, done;
    logic       tick;
    logic [7:0] dbg_mode;
    logic [2:0] q3, done3;
    logic       tick3;
    logic [5:0] dbg_mode3;

    led_channel_timer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ),
        .CHANNELS(CHANNELS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .q(q), .done(done), .tick(tick), .dbg_mode(dbg_mode)
    );

    led_channel_timer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ),
        .CHANNELS(3), .CNT_WIDTH(CNT_WIDTH)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .q(q3), .done(done3), .tick(tick3), .dbg_mode(dbg_mode3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model.
    int m_k;
    int m_mode [CHANNELS];
    int m_eff  [CHANNELS];
    int m_ts   [CHANNELS];
    bit m_done [CHANNELS];

    logic [3:0] eq, ed;
    logic [7:0] em;
    logic       et;

    task automatic model_reset();
        m_k = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_mode[i] = 0;
            m_eff[i]  = 1;
            m_ts[i]   = 0;
            m_done[i] = 1'b0;
        end
    endtask

    // Tick during the current cycle: the PRESCALE-th cycle after release.
    function automatic logic m_tick();
        return ((m_k + 1) % PRESCALE) == 0;
    endfunction

    function automatic logic [3:0] m_q();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (m_mode[i])
                1:       r[i] = 1'b1;
                2:       r[i] = ((m_ts[i] / m_eff[i]) % 2) != 0;
                3:       r[i] = m_ts[i] < m_eff[i];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] m_dn();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) r[i] = m_done[i];
        return r;
    endfunction

    function automatic logic [7:0] m_md();
        logic [7:0] r;
        logic [1:0] md;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            md = 2'(m_mode[i]);
            if (m_mode[i] == 3 && m_ts[i] >= m_eff[i]) md = 2'd0;
            r[2*i +: 2] = md;
        end
        return r;
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        logic t;
        t = m_tick();
        for (int i = 0; i < CHANNELS; i++) begin
            m_done[i] = 1'b0;
            if (cfg_we && int'(cfg_addr) == i) begin
                m_mode[i] = int'(cfg_mode);
                m_eff[i]  = (cfg_period == 0) ? 1 : int'(cfg_period);
                m_ts[i]   = 0;
            end else if (t) begin
                if (m_mode[i] == 2) begin
                    m_ts[i]++;
                end else if (m_mode[i] == 3 && m_ts[i] < m_eff[i]) begin
                    m_ts[i]++;
                    if (m_ts[i] == m_eff[i]) m_done[i] = 1'b1;
                end
            end
        end
        m_k++;
    endtask

    // Driver tasks.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        eq = m_q();
        ed = m_dn();
        em = m_md();
        et = m_tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [1:0] m,
                            input logic [CNT_WIDTH-1:0] p);
        cfg_we     = 1'b1;
        cfg_addr   = a;
        cfg_mode   = m;
        cfg_period = p;
        step();
        cfg_we = 1'b0;
    endtask

    // Tests.
    task automatic test_reset();
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0; cfg_period = '0;
        model_reset();
        #12;
        n_cmp++;
        if ({q, done, tick, dbg_mode, q3, done3, tick3} !== '0) begin
            n_err++;
            $display("FAIL reset_state q=%b done=%b tick=%b mode=%h q3=%b done3=%b required all zero",
                     q, done, tick, dbg_mode, q3, done3);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 32; c++) begin
            step();
            n_cmp++;
            if ({q, done, tick, dbg_mode} !== {4'b0, 4'b0, et, 8'h00}) begin
                n_err++;
                $display("FAIL idle_tick c=%0d q=%b done=%b tick=%b mode=%h req tick=%b",
                         c + 1, q, done, tick, dbg_mode, et);
            end
        end
    endtask

    task automatic test_blink();
        do_write(2'd0, 2'b10, 8'd3);
        n_cmp++;
        if (q[0] !== 1'b0) begin
            n_err++;
            $display("FAIL blink_start q0=%b required 0", q[0]);
        end
        for (int c = 0; c < 130; c++) begin
            step();
            n_cmp++;
            if ({q, done, tick, dbg_mode} !== {eq, ed, et, em}) begin
                n_err++;
                $display("FAIL blink c=%0d got q=%b done=%b tick=%b mode=%h req q=%b done=%b tick=%b mode=%h",
                         c, q, done, tick, dbg_mode, eq, ed, et, em);
            end
        end
    endtask

    task automatic test_oneshot();
        int pulses;
        pulses = 0;
        do_write(2'd1, 2'b11, 8'd2);
        n_cmp++;
        if (q[1] !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_start q1=%b required 1", q[1]);
        end
        for (int c = 0; c < 60; c++) begin
            step();
            if (done[1] === 1'b1) pulses++;
            n_cmp++;
            if ({q, done, tick, dbg_mode} !== {eq, ed, et, em}) begin
                n_err++;
                $display("FAIL oneshot c=%0d got q=%b done=%b tick=%b mode=%h req q=%b done=%b tick=%b mode=%h",
                         c, q, done, tick, dbg_mode, eq, ed, et, em);
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL oneshot_done_count got=%0d required=1", pulses);
        end
    endtask

    task automatic test_zero_on_invalid();
        do_write(2'd2, 2'b10, 8'd0);
        do_write(2'd3, 2'b01, 8'd7);
        do_write(2'd3, 2'b11, 8'd4);
        for (int c = 0; c < 70; c++) begin
            step();
            n_cmp++;
            if ({q, done, tick, dbg_mode} !== {eq, ed, et, em}) begin
                n_err++;
                $display("FAIL ch23 c=%0d got q=%b done=%b tick=%b mode=%h req q=%b done=%b tick=%b mode=%h",
                         c, q, done, tick, dbg_mode, eq, ed, et, em);
            end
            n_cmp++;
            if ({q3, done3, tick3, dbg_mode3} !== {eq[2:0], ed[2:0], et, em[5:0]}) begin
                n_err++;
                $display("FAIL addr_ignored c=%0d got q3=%b done3=%b mode3=%h req q3=%b done3=%b mode3=%h",
                         c, q3, done3, dbg_mode3, eq[2:0], ed[2:0], em[5:0]);
            end
        end
    endtask

    task automatic test_write_on_tick();
        for (int c = 0; c < PRESCALE && !m_tick(); c++) step();
        n_cmp++;
        if (tick !== 1'b1) begin
            n_err++;
            $display("FAIL tick_align got=%b required=1", tick);
        end
        do_write(2'd0, 2'b10, 8'd1);
        for (int c = 0; c < 45; c++) begin
            step();
            n_cmp++;
            if ({q, done, tick, dbg_mode} !== {eq, ed, et, em}) begin
                n_err++;
                $display("FAIL wr_on_tick c=%0d got q=%b done=%b tick=%b mode=%h req q=%b done=%b tick=%b mode=%h",
                         c, q, done, tick, dbg_mode, eq, ed, et, em);
            end
        end
    endtask

    task automatic test_max_period();
        do_write(2'd3, 2'b11, 8'd255);
        for (int c = 0; c < 2580; c++) begin
            step();
            n_cmp++;
            if ({q, done, tick, dbg_mode} !== {eq, ed, et, em}) begin
                n_err++;
                $display("FAIL max_period c=%0d got q=%b done=%b tick=%b mode=%h req q=%b done=%b tick=%b mode=%h",
                         c, q, done, tick, dbg_mode, eq, ed, et, em);
            end
        end
    endtask

    task automatic test_random();
        int idle;
        logic [CNT_WIDTH-1:0] p;
        for (int n = 0; n < 50; n++) begin
            idle = $urandom_range(0, 25);
            for (int c = 0; c < idle; c++) begin
                step();
                n_cmp++;
                if ({q, done, tick, dbg_mode, q3, done3} !== {eq, ed, et, em, eq[2:0], ed[2:0]}) begin
                    n_err++;
                    $display("FAIL random n=%0d got q=%b done=%b tick=%b mode=%h q3=%b done3=%b req q=%b done=%b tick=%b mode=%h",
                             n, q, done, tick, dbg_mode, q3, done3, eq, ed, et, em);
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < PRESCALE && !m_tick(); c++) step();
            end
            p = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 4));
            do_write(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), p);
            n_cmp++;
            if ({q, done, dbg_mode} !== {eq, ed, em}) begin
                n_err++;
                $display("FAIL random_write n=%0d got q=%b done=%b mode=%h req q=%b done=%b mode=%h",
                         n, q, done, dbg_mode, eq, ed, em);
            end
        end
    endtask

    task automatic test_async_reset();
        do_write(2'd0, 2'b10, 8'd1);
        do_write(2'd1, 2'b11, 8'd20);
        for (int c = 0; c < 25; c++) step();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({q, done, tick, dbg_mode, q3, done3} !== '0) begin
            n_err++;
            $display("FAIL async_reset q=%b done=%b tick=%b mode=%h q3=%b required all zero",
                     q, done, tick, dbg_mode, q3);
        end
        @(posedge clk);
        #2;
        n_cmp++;
        if ({q, done, tick, dbg_mode} !== '0) begin
            n_err++;
            $display("FAIL reset_held q=%b done=%b tick=%b mode=%h required all zero",
                     q, done, tick, dbg_mode);
        end
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 32; c++) begin
            step();
            n_cmp++;
            if ({q, done, tick, dbg_mode} !== {4'b0, 4'b0, et, 8'h00}) begin
                n_err++;
                $display("FAIL post_reset c=%0d q=%b done=%b tick=%b mode=%h req tick=%b",
                         c + 1, q, done, tick, dbg_mode, et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_oneshot();
        test_zero_on_invalid();
        test_write_on_tick();
        test_max_period();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_channel_timer.md
Name: led_channel_timer

Overview:
- Parametrised successor to the single-LED toggle divider: N independent output channels share one prescaler that produces a tick at TICK_HZ.
- Each channel is configured at runtime as OFF, ON, BLINK (programmable half-period) or ONESHOT (pulse of programmable length, with a completion strobe).
- Sits between the SoC control logic and the board LEDs/GPIO, clocked from the board clock.

Parameters:
- CLK_FREQ_HZ, 16_000_000, input clock frequency.
- TICK_HZ, 1000, tick rate. PRESCALE = CLK_FREQ_HZ/TICK_HZ; elaboration must fail if PRESCALE < 2.
- CHANNELS, 4, number of output channels (1..16).
- CNT_WIDTH, 16, width of the per-channel period and counter.
- AW = max(1, $clog2(CHANNELS)), derived, never overridden.

Ports:
- clk  in  1  board clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  configuration write strobe; 1 cycle = 1 write.
- cfg_addr  in  AW  channel index.
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
- cfg_period  in  CNT_WIDTH  period in ticks.
- q  out  CHANNELS  channel outputs, registered.
- done  out  CHANNELS  1-cycle ONESHOT completion strobe, registered.
- tick  out  1  prescaler tick, 1-cycle pulse.

Behaviour:
- Reset (async, rst_n=0):
  - prescaler=0; every channel mode=OFF, period=0, cnt=0; q=0, done=0.
  - tick=0 because the prescaler is 0.
  - Takes effect immediately, including mid-blink and mid-oneshot. No state survives reset.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick = (prescaler == PRESCALE-1), combinational decode.
  - The first tick after reset release is the PRESCALE-th cycle; ticks repeat every PRESCALE cycles.
  - Free-running; configuration writes never affect it.
- Effective period: eff = (period == 0) ? 1 : period.
- Configuration write (cfg_we=1, cfg_addr < CHANNELS), registered on the edge:
  - mode <= cfg_mode, period <= cfg_period, cnt <= 0, done <= 0.
  - q: OFF -> 0; ON -> 1; BLINK -> 0 (phase restart); ONESHOT -> 1.
  - A write with cfg_addr >= CHANNELS is ignored with no state change.
  - A write has priority over that channel's tick processing in the same cycle; the tick is consumed and lost for that channel.
  - Other channels process the tick normally.
- OFF / ON: cnt held at 0; q constant; tick ignored.
- BLINK, on each tick:
  - If cnt == eff-1: q <= ~q, cnt <= 0; otherwise cnt <= cnt+1.
  - Full blink cycle = 2*eff ticks. Runs indefinitely.
- ONESHOT, on each tick:
  - If cnt == eff-1: q <= 0, mode <= OFF, cnt <= 0, done <= 1 for exactly one cycle. q falls in the same cycle done asserts.
  - Otherwise cnt <= cnt+1.
  - High time = (eff-1)*PRESCALE + cycles-to-first-tick.
- done deasserts the cycle after it pulses.
- Rewriting a channel while ONESHOT is active restarts it; no done is issued for the aborted shot.
- Widths:
  - cnt never exceeds eff-1, so it never wraps.
  - period = 2^CNT_WIDTH-1 must be legal.
- Channels are fully independent. Simultaneous writes are impossible (single port); simultaneous expiries on several channels each pulse their own done bit.

Test Plan (CLK_FREQ_HZ=100, TICK_HZ=10 → PRESCALE=10, CHANNELS=4, CNT_WIDTH=8):
- Release reset, no writes -> tick high on cycles 10, 20, 30 after release (1 cycle each); q=0000, done=0000 throughout.
- Write ch0 BLINK period=3 immediately after reset -> q[0]=0 after write; toggles to 1 on the 3rd tick (cycle 30), to 0 on the 6th (cycle 60); period 60 cycles sustained; other q bits stay 0.
- Write ch1 ONESHOT period=2 -> q[1]=1 the cycle after write; falls on the 2nd subsequent tick with done[1]=1 for exactly one cycle; mode returns to OFF; later ticks leave q[1]=0.
- Write ch2 BLINK period=0 -> q[2] toggles on every tick (20-cycle full period). Write ch3 ON -> q[3]=1 steady. Then write cfg_addr=5 (AW=2 truncation disallowed; bench uses CHANNELS=3 variant, addr=3) -> no state change.
- Write ch0 in the exact cycle tick=1 -> write values applied and cnt=0; tick not counted for ch0. Channel 2 toggles normally on the same tick.
- Assert rst_n=0 mid-blink and mid-oneshot, asynchronously between edges -> q and done go 0 immediately; after release all channels are OFF and tick resumes at cycle 10.
